// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: MEM-stage state encoding, word-alignment
// mask, default access timeout and the branch-resolution helper.
package mips_pipe_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic [31:0]  WORD_ALIGN_MASK        = 32'h0000_0003;
  localparam int unsigned  DEFAULT_TIMEOUT_CYCLES = 16;

  // BEQ has priority when both branch controls are set.
  function automatic logic branch_taken(input logic beq, input logic bne, input logic zero);
    return beq ? zero : (bne & ~zero);
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// ACCESS-cycle counter for the MEM stage. terminal is high during the
// LIMIT-th consecutive enabled cycle. Only built when MEM_STAGE_TIMEOUT_EN is defined.
module mem_timeout_counter
  import mips_pipe_pkg::*;
#(
  parameter int unsigned LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  assign terminal = enable && (count == CNT_W'(LIMIT - 1));

  // Count enabled cycles, saturating at the terminal value; clear while idle.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_stage_access_unit.sv
// MEM stage: load/store through a req/ack data-memory handshake, upstream
// stall while waiting, BEQ/BNE resolution and MEM/WB write-back presentation.
// Optional access timeout (bus error) enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage_access_unit
  import mips_pipe_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_Valid,
  input  logic [31:0]       in_ALUResult,
  input  logic [31:0]       in_ReadData2,
  input  logic              in_Zero,
  input  logic [31:0]       in_BranchAddress,
  input  logic              in_CtrlMemRead,
  input  logic              in_CtrlMemWrite,
  input  logic              in_CtrlALUOrMem,
  input  logic              in_CtrlBranchEquals,
  input  logic              in_CtrlBranchNotEquals,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              out_Stall,
  output logic              out_Valid,
  output logic [31:0]       out_WriteData,
  output logic              out_PCSrc,
  output logic [31:0]       out_BranchTarget,
  output logic              out_MisalignErr,
  output logic              out_BusErr
);

  state_t      state;
  logic        memOp;
  logic        aligned;
  logic        inAccess;
  logic        timeoutHit;

  // Fields held stable for the whole access
  logic [31:0] aluRes_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        aluOrMem_q;
  logic        zero_q;
  logic        beq_q;
  logic        bne_q;
  logic [31:0] target_q;

  assign memOp    = in_Valid & (in_CtrlMemRead | in_CtrlMemWrite);
  assign aligned  = (in_ALUResult & WORD_ALIGN_MASK) == '0;
  assign inAccess = (state == ST_ACCESS);

  // Bus outputs derive from state so reset removes a pending request immediately.
  assign mem_req   = inAccess;
  assign mem_we    = inAccess & we_q;
  assign mem_addr  = inAccess ? aluRes_q[ADDR_W-1:0] : '0;
  assign mem_wdata = inAccess ? wdata_q : '0;

`ifdef MEM_STAGE_TIMEOUT_EN
  mem_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear    (~inAccess),
    .enable   (inAccess),
    .terminal (timeoutHit)
  );

  // Bus error flags a timed-out access; an ack on the terminal cycle wins.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      out_BusErr <= 1'b0;
    end else begin
      out_BusErr <= inAccess & ~mem_ack & timeoutHit;
    end
  end
`else
  assign timeoutHit = 1'b0;
  assign out_BusErr = 1'b0;
`endif

  // Upstream freeze: launching an access, or waiting for ack/timeout.
  always_comb begin
    out_Stall = 1'b0;
    if (state == ST_IDLE) begin
      out_Stall = memOp & aligned;
    end else begin
      out_Stall = ~mem_ack & ~timeoutHit;
    end
  end

  // Access FSM with registered MEM/WB outputs; outputs are zero on bubble cycles.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ST_IDLE;
      aluRes_q         <= '0;
      wdata_q          <= '0;
      we_q             <= 1'b0;
      aluOrMem_q       <= 1'b0;
      zero_q           <= 1'b0;
      beq_q            <= 1'b0;
      bne_q            <= 1'b0;
      target_q         <= '0;
      out_Valid        <= 1'b0;
      out_WriteData    <= '0;
      out_PCSrc        <= 1'b0;
      out_BranchTarget <= '0;
      out_MisalignErr  <= 1'b0;
    end else begin
      out_Valid        <= 1'b0;
      out_WriteData    <= '0;
      out_PCSrc        <= 1'b0;
      out_BranchTarget <= '0;
      out_MisalignErr  <= 1'b0;
      if (state == ST_IDLE) begin
        if (memOp && aligned) begin
          aluRes_q   <= in_ALUResult;
          wdata_q    <= in_ReadData2;
          we_q       <= in_CtrlMemWrite;
          aluOrMem_q <= in_CtrlALUOrMem;
          zero_q     <= in_Zero;
          beq_q      <= in_CtrlBranchEquals;
          bne_q      <= in_CtrlBranchNotEquals;
          target_q   <= in_BranchAddress;
          state      <= ST_ACCESS;
        end else if (in_Valid) begin
          out_Valid        <= 1'b1;
          out_WriteData    <= memOp ? '0 : in_ALUResult;
          out_MisalignErr  <= memOp;
          out_PCSrc        <= branch_taken(in_CtrlBranchEquals, in_CtrlBranchNotEquals, in_Zero);
          out_BranchTarget <= in_BranchAddress;
        end
      end else begin
        if (mem_ack) begin
          state            <= ST_IDLE;
          out_Valid        <= 1'b1;
          out_WriteData    <= (aluOrMem_q & ~we_q) ? mem_rdata : aluRes_q;
          out_PCSrc        <= branch_taken(beq_q, bne_q, zero_q);
          out_BranchTarget <= target_q;
        end else if (timeoutHit) begin
          state     <= ST_IDLE;
          out_Valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Self-checking bench for mem_stage_access_unit: vector table plus hand
// sequences; expected completions are queued when issued and popped by a monitor.
module tb_mem_stage_access_unit;

  logic        clk;
  logic        reset;
  logic        in_Valid;
  logic [31:0] in_ALUResult;
  logic [31:0] in_ReadData2;
  logic        in_Zero;
  logic [31:0] in_BranchAddress;
  logic        in_CtrlMemRead;
  logic        in_CtrlMemWrite;
  logic        in_CtrlALUOrMem;
  logic        in_CtrlBranchEquals;
  logic        in_CtrlBranchNotEquals;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_Stall;
  logic        out_Valid;
  logic [31:0] out_WriteData;
  logic        out_PCSrc;
  logic [31:0] out_BranchTarget;
  logic        out_MisalignErr;
  logic        out_BusErr;

  mem_stage_access_unit #(
    .ADDR_W         (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .in_Valid               (in_Valid),
    .in_ALUResult           (in_ALUResult),
    .in_ReadData2           (in_ReadData2),
    .in_Zero                (in_Zero),
    .in_BranchAddress       (in_BranchAddress),
    .in_CtrlMemRead         (in_CtrlMemRead),
    .in_CtrlMemWrite        (in_CtrlMemWrite),
    .in_CtrlALUOrMem        (in_CtrlALUOrMem),
    .in_CtrlBranchEquals    (in_CtrlBranchEquals),
    .in_CtrlBranchNotEquals (in_CtrlBranchNotEquals),
    .mem_req                (mem_req),
    .mem_we                 (mem_we),
    .mem_addr               (mem_addr),
    .mem_wdata              (mem_wdata),
    .mem_ack                (mem_ack),
    .mem_rdata              (mem_rdata),
    .out_Stall              (out_Stall),
    .out_Valid              (out_Valid),
    .out_WriteData          (out_WriteData),
    .out_PCSrc              (out_PCSrc),
    .out_BranchTarget       (out_BranchTarget),
    .out_MisalignErr        (out_MisalignErr),
    .out_BusErr             (out_BusErr)
  );

  // DUT state changes on negedge; bench drives at negedge+1 and samples at posedge.
  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wdata;
    logic        pcsrc;
    logic [31:0] target;
    logic        misalign;
    logic        buserr;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic        zero;
    logic [31:0] br;
    logic        rd;
    logic        wr;
    logic        aom;
    logic        beq;
    logic        bne;
    int unsigned ackDelay;
    logic [31:0] rdata;
    exp_t        exp;
  } vec_t;

  exp_t sb[$];
  exp_t monE;
  int   errors = 0;
  int   checks = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [31:0] alu, input logic [31:0] rd2,
                              input logic zero, input logic [31:0] br, input logic rd, input logic wr,
                              input logic aom, input logic beq, input logic bne,
                              input int unsigned ackDelay, input logic [31:0] rdata,
                              input logic [31:0] eWdata, input logic ePc, input logic [31:0] eTarget,
                              input logic eMis);
    vec_t v;
    v.name = name; v.alu = alu; v.rd2 = rd2; v.zero = zero; v.br = br;
    v.rd = rd; v.wr = wr; v.aom = aom; v.beq = beq; v.bne = bne;
    v.ackDelay = ackDelay; v.rdata = rdata;
    v.exp.wdata = eWdata; v.exp.pcsrc = ePc; v.exp.target = eTarget;
    v.exp.misalign = eMis; v.exp.buserr = 1'b0;
    return v;
  endfunction

  // Completion monitor: every out_Valid pulse must match the oldest queued expectation.
  always @(posedge clk) begin
    if (reset) begin
      if (out_Valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got out_Valid=1 expected no completion at %0t", $time);
        end else begin
          monE = sb.pop_front();
          check32("wb_data",   out_WriteData,    monE.wdata);
          check32("pcsrc",     out_PCSrc,        monE.pcsrc);
          check32("br_target", out_BranchTarget, monE.target);
          check32("misalign",  out_MisalignErr,  monE.misalign);
          check32("buserr",    out_BusErr,       monE.buserr);
        end
      end else begin
        check32("bubble_data",  out_WriteData | out_BranchTarget, 32'h0);
        check32("bubble_flags", {out_PCSrc, out_MisalignErr, out_BusErr}, 32'h0);
      end
    end
  end

  task automatic idleInputs();
    in_Valid = 1'b0; in_ALUResult = '0; in_ReadData2 = '0; in_Zero = 1'b0;
    in_BranchAddress = '0; in_CtrlMemRead = 1'b0; in_CtrlMemWrite = 1'b0;
    in_CtrlALUOrMem = 1'b0; in_CtrlBranchEquals = 1'b0; in_CtrlBranchNotEquals = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic issue(input vec_t v);
    logic        memop;
    logic        algn;
    int unsigned stallCnt;
    memop = v.rd | v.wr;
    algn  = (v.alu[1:0] == 2'b00);
    stallCnt = 0;
    @(negedge clk); #1;
    in_Valid = 1'b1; in_ALUResult = v.alu; in_ReadData2 = v.rd2; in_Zero = v.zero;
    in_BranchAddress = v.br; in_CtrlMemRead = v.rd; in_CtrlMemWrite = v.wr;
    in_CtrlALUOrMem = v.aom; in_CtrlBranchEquals = v.beq; in_CtrlBranchNotEquals = v.bne;
    mem_ack = 1'b0;
    sb.push_back(v.exp);
    @(posedge clk);
    check32({v.name, "_req_issue"}, mem_req, 32'h0);
    if (out_Stall) stallCnt++;
    @(negedge clk); #1;
    idleInputs();
    if (memop && algn) begin
      for (int unsigned c = 0; c <= v.ackDelay; c++) begin
        if (c == v.ackDelay) begin
          mem_ack = 1'b1;
          mem_rdata = v.rdata;
        end
        @(posedge clk);
        check32({v.name, "_req"},  mem_req,  32'h1);
        check32({v.name, "_addr"}, mem_addr, v.alu);
        check32({v.name, "_we"},   mem_we,   v.wr);
        if (v.wr) check32({v.name, "_wdata"}, mem_wdata, v.rd2);
        if (out_Stall) stallCnt++;
        @(negedge clk); #1;
        mem_ack = 1'b0;
        mem_rdata = 32'hBAD0_BAD0;
      end
    end else begin
      @(posedge clk);
      check32({v.name, "_noreq"}, mem_req, 32'h0);
    end
    check32({v.name, "_stall_cycles"}, stallCnt, (memop && algn) ? 1 + v.ackDelay : 0);
    drain(v.name);
  endtask

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    //         name        alu           rd2           z     br         rd wr aom beq bne dly rdata         eWdata        ePc eTarget   eMis
    vecs[0]  = mk("alu",    32'h0000_1234, 32'h0,        0, 32'h0,     0, 0, 0, 0, 0, 0, 32'h0,        32'h0000_1234, 0, 32'h0,     0);
    vecs[1]  = mk("ld40",   32'h0000_0040, 32'h0,        0, 32'h0,     1, 0, 1, 0, 0, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 32'h0,     0);
    vecs[2]  = mk("st80",   32'h0000_0080, 32'hA5A5_A5A5, 0, 32'h0,    0, 1, 0, 0, 0, 0, 32'h0,        32'h0000_0080, 0, 32'h0,     0);
    vecs[3]  = mk("ld42",   32'h0000_0042, 32'h0,        0, 32'h0,     1, 0, 1, 0, 0, 0, 32'h0,        32'h0,         0, 32'h0,     1);
    vecs[4]  = mk("beq_t",  32'h0,         32'h0,        1, 32'h100,   0, 0, 0, 1, 0, 0, 32'h0,        32'h0,         1, 32'h100,   0);
    vecs[5]  = mk("bne_nt", 32'h0,         32'h0,        1, 32'h200,   0, 0, 0, 0, 1, 0, 32'h0,        32'h0,         0, 32'h200,   0);
    vecs[6]  = mk("bne_t",  32'h5,         32'h0,        0, 32'h300,   0, 0, 0, 0, 1, 0, 32'h0,        32'h5,         1, 32'h300,   0);
    vecs[7]  = mk("both",   32'h7,         32'h0,        0, 32'h400,   0, 0, 0, 1, 1, 0, 32'h0,        32'h7,         0, 32'h400,   0);
    vecs[8]  = mk("ld_alu", 32'h0000_007C, 32'h0,        0, 32'h0,     1, 0, 0, 0, 0, 1, 32'h1111_1111, 32'h0000_007C, 0, 32'h0,     0);
    vecs[9]  = mk("st81",   32'h0000_0081, 32'h1234_5678, 0, 32'h0,    0, 1, 0, 0, 0, 0, 32'h0,        32'h0,         0, 32'h0,     1);
    vecs[10] = mk("ld_top", 32'hFFFF_FFFC, 32'h0,        0, 32'h0,     1, 0, 1, 0, 0, 4, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 32'h0,     0);
    vecs[11] = mk("st_aom", 32'h0000_0010, 32'h0BAD_F00D, 0, 32'h0,    0, 1, 1, 0, 0, 1, 32'h7777_7777, 32'h0000_0010, 0, 32'h0,     0);

    idleInputs();
    mem_ack = 1'b0;
    mem_rdata = '0;
    reset = 1'b0;
    #2;
    check32("rst_req",   {mem_req, mem_we, out_Stall}, 32'h0);
    check32("rst_bus",   mem_addr | mem_wdata, 32'h0);
    check32("rst_valid", {out_Valid, out_PCSrc, out_MisalignErr, out_BusErr}, 32'h0);
    check32("rst_data",  out_WriteData | out_BranchTarget, 32'h0);
    @(negedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 12; i++) issue(vecs[i]);

    // Ack and non-valid memory controls while idle must not start anything.
    @(negedge clk); #1;
    in_CtrlMemRead = 1'b1; in_ALUResult = 32'h40; mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      check32("idle_ack_req",   mem_req,   32'h0);
      check32("idle_ack_stall", out_Stall, 32'h0);
    end
    @(negedge clk); #1;
    idleInputs();
    mem_ack = 1'b0;

    // Reset in the middle of an access drops the request at once.
    @(negedge clk); #1;
    in_Valid = 1'b1; in_CtrlMemRead = 1'b1; in_ALUResult = 32'h40;
    @(negedge clk); #1;
    idleInputs();
    @(posedge clk);
    check32("pre_rst_req", mem_req, 32'h1);
    #1 reset = 1'b0;
    #1;
    check32("mid_rst_req",   mem_req,   32'h0);
    check32("mid_rst_stall", out_Stall, 32'h0);
    check32("mid_rst_addr",  mem_addr,  32'h0);
    @(negedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      check32("post_rst_req", mem_req, 32'h0);
    end

`ifdef MEM_STAGE_TIMEOUT_EN
    // No ack: sixteen ACCESS cycles then a bus-error completion.
    @(negedge clk); #1;
    in_Valid = 1'b1; in_CtrlMemRead = 1'b1; in_CtrlALUOrMem = 1'b1; in_ALUResult = 32'h40;
    sb.push_back('{wdata: 32'h0, pcsrc: 1'b0, target: 32'h0, misalign: 1'b0, buserr: 1'b1});
    @(negedge clk); #1;
    idleInputs();
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      check32("tmo_req", mem_req, 32'h1);
      check32("tmo_stall", out_Stall, (i == 15) ? 32'h0 : 32'h1);
    end
    @(posedge clk);
    check32("tmo_req_drop", mem_req, 32'h0);
    drain("tmo");
    // Ack on the terminal cycle completes normally.
    issue(mk("tmo_ack", 32'h0000_0044, 32'h0, 0, 32'h0, 1, 0, 1, 0, 0, 15, 32'h600D_D00D,
             32'h600D_D00D, 0, 32'h0, 0));
`else
    // Without the timeout an unacknowledged access simply keeps waiting.
    issue(mk("long_wait", 32'h0000_0044, 32'h0, 0, 32'h0, 1, 0, 1, 0, 0, 20, 32'h600D_D00D,
             32'h600D_D00D, 0, 32'h0, 0));
`endif

    repeat (3) @(negedge clk);
    check32("sb_empty", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
